// File: rtl/btn_event_queue.sv
// rtl/btn_event_queue.sv - button sync/debounce with press pulses and a 4-entry press-event FIFO
module btn_event_queue #(
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    input  logic       evt_ack,
    output logic [2:0] evt_count,
    output logic [7:0] drop_cnt
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       rise;
    logic [2:0]       pend;
    logic [2:0]       grant;
    logic [2:0]       clr;
    logic [2:0]       drop;
    logic [1:0]       push_id;
    logic             pop;
    logic             push;
    logic             can_write;
    logic [8:0]       drop_sum;
    logic [1:0]       mem [4];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // A channel rises in the same edge its debounced level flips to 1.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rise[i] = sync_b[i] & ~btn_level[i] & (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level <= '0;
            btn_press <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_press <= rise;
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    btn_level[i] <= sync_b[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign evt_valid = (evt_count != 3'd0);
    assign pop       = evt_valid & evt_ack;
    assign can_write = (evt_count != 3'd4) | pop;
    assign evt_id    = evt_valid ? mem[rd_ptr] : 2'd0;

    always_comb begin
        grant   = 3'b000;
        push_id = 2'd0;
        if (pend[0]) begin
            grant   = 3'b001;
            push_id = 2'd1;
        end else if (pend[1]) begin
            grant   = 3'b010;
            push_id = 2'd2;
        end else if (pend[2]) begin
            grant   = 3'b100;
            push_id = 2'd3;
        end
    end

    assign push     = can_write & (pend != 3'b000);
    assign clr      = push ? grant : 3'b000;
    assign drop     = btn_press & pend & ~clr;
    assign drop_sum = {1'b0, drop_cnt} + {8'd0, drop[0]} + {8'd0, drop[1]} + {8'd0, drop[2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            drop_cnt <= '0;
        end else begin
            pend     <= (pend & ~clr) | btn_press;
            drop_cnt <= (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        end
    end

    // Storage is not reset; evt_id is gated by evt_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            evt_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   evt_count <= evt_count + 3'd1;
                2'b01:   evt_count <= evt_count - 3'd1;
                default: evt_count <= evt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_event_queue.sv
// tb/tb_btn_event_queue.sv - scenario tasks with an expected-ID scoreboard for btn_event_queue
module tb_btn_event_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic       evt_ack = 1'b0;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [2:0] evt_count;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int exp_id;

    btn_event_queue #(.DEB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .evt_valid(evt_valid),
        .evt_id(evt_id),
        .evt_ack(evt_ack),
        .evt_count(evt_count),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        evt_ack = 1'b1;
        cyc(1);
        evt_ack = 1'b0;
    endtask

    task automatic press_btn(input int i, input bit queued);
        btn_raw[i] = 1'b1;
        if (queued) sb.push_back(i + 1);
        cyc(7);
        btn_raw[i] = 1'b0;
        cyc(7);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        checks++;
        if ({btn_level, btn_press, evt_valid, evt_id, evt_count, drop_cnt} !== 20'd0) begin
            errors++;
            $display("FAIL reset_state: got lvl=%b prs=%b v=%b id=%0d cnt=%0d drop=%0d, want all 0",
                     btn_level, btn_press, evt_valid, evt_id, evt_count, drop_cnt);
        end
        rst = 1'b0;
        cyc(1);
    endtask

    task automatic test_clean_press();
        btn_raw[1] = 1'b1;
        sb.push_back(2);
        cyc(5);
        checks++;
        if (btn_level !== 3'b000) begin
            errors++;
            $display("FAIL clean_early_level: got %b want 000", btn_level);
        end
        cyc(1);
        checks++;
        if (btn_level !== 3'b010 || btn_press !== 3'b010) begin
            errors++;
            $display("FAIL clean_rise: got lvl=%b prs=%b want 010/010", btn_level, btn_press);
        end
        cyc(1);
        checks++;
        if (btn_press !== 3'b000 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_pulse_width: got prs=%b v=%b want 000/0", btn_press, evt_valid);
        end
        cyc(1);
        exp_id = sb.size() > 0 ? sb.pop_front() : -1;
        checks++;
        if (evt_valid !== 1'b1 || int'(evt_id) !== exp_id || evt_count !== 3'd1) begin
            errors++;
            $display("FAIL clean_event: got v=%b id=%0d cnt=%0d want 1/%0d/1", evt_valid, evt_id, evt_count, exp_id);
        end
        cyc(12);
        btn_raw[1] = 1'b0;
        cyc(8);
        checks++;
        if (btn_level !== 3'b000 || evt_count !== 3'd1) begin
            errors++;
            $display("FAIL clean_release: got lvl=%b cnt=%0d want 000/1", btn_level, evt_count);
        end
        ack_pulse();
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL clean_drain: got v=%b id=%0d want 0/0", evt_valid, evt_id);
        end
    endtask

    task automatic test_bounce();
        bit seen_level = 0;
        bit seen_press = 0;
        bit seen_valid = 0;
        for (int t = 0; t < 26; t++) begin
            btn_raw[0] = (t < 12) ? ~t[1] : 1'b0;
            cyc(1);
            if (btn_level != 3'b000) seen_level = 1;
            if (btn_press != 3'b000) seen_press = 1;
            if (evt_valid != 1'b0) seen_valid = 1;
        end
        checks++;
        if (seen_level || seen_press || seen_valid) begin
            errors++;
            $display("FAIL bounce: got level_seen=%b press_seen=%b valid_seen=%b want 0/0/0",
                     seen_level, seen_press, seen_valid);
        end
    endtask

    task automatic test_simultaneous();
        btn_raw = 3'b101;
        sb.push_back(1);
        sb.push_back(3);
        cyc(6);
        checks++;
        if (btn_press !== 3'b101) begin
            errors++;
            $display("FAIL simul_press: got %b want 101", btn_press);
        end
        cyc(2);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_count !== 3'd1) begin
            errors++;
            $display("FAIL simul_first: got v=%b id=%0d cnt=%0d want 1/1/1", evt_valid, evt_id, evt_count);
        end
        cyc(1);
        checks++;
        if (evt_count !== 3'd2) begin
            errors++;
            $display("FAIL simul_count: got %0d want 2", evt_count);
        end
        btn_raw = 3'b000;
        cyc(8);
        for (int k = 0; k < 2; k++) begin
            exp_id = sb.size() > 0 ? sb.pop_front() : -1;
            checks++;
            if (evt_valid !== 1'b1 || int'(evt_id) !== exp_id) begin
                errors++;
                $display("FAIL simul_pop%0d: got v=%b id=%0d want 1/%0d", k, evt_valid, evt_id, exp_id);
            end
            ack_pulse();
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got v=%b want 0", evt_valid);
        end
    endtask

    task automatic test_ack_empty();
        bit bad = 0;
        evt_ack = 1'b1;
        for (int t = 0; t < 5; t++) begin
            cyc(1);
            if (evt_valid != 1'b0 || evt_count != 3'd0) bad = 1;
        end
        evt_ack = 1'b0;
        checks++;
        if (bad || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ack_empty: got changed=%b cnt=%0d drop=%0d want 0/0/0", bad, evt_count, drop_cnt);
        end
    endtask

    task automatic test_full_drop();
        press_btn(0, 1);
        press_btn(1, 1);
        press_btn(2, 1);
        press_btn(0, 1);
        press_btn(1, 1);
        checks++;
        if (evt_count !== 3'd4 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL full_count: got cnt=%0d drop=%0d want 4/0", evt_count, drop_cnt);
        end
        press_btn(1, 0);
        checks++;
        if (drop_cnt !== 8'd1 || evt_count !== 3'd4) begin
            errors++;
            $display("FAIL full_drop: got drop=%0d cnt=%0d want 1/4", drop_cnt, evt_count);
        end
        exp_id = sb.size() > 0 ? sb.pop_front() : -1;
        checks++;
        if (int'(evt_id) !== exp_id) begin
            errors++;
            $display("FAIL full_head: got id=%0d want %0d", evt_id, exp_id);
        end
        ack_pulse();
        checks++;
        if (evt_count !== 3'd4) begin
            errors++;
            $display("FAIL full_pop_push: got cnt=%0d want 4", evt_count);
        end
        for (int k = 0; k < 4; k++) begin
            exp_id = sb.size() > 0 ? sb.pop_front() : -1;
            checks++;
            if (evt_valid !== 1'b1 || int'(evt_id) !== exp_id) begin
                errors++;
                $display("FAIL full_order%0d: got v=%b id=%0d want 1/%0d", k, evt_valid, evt_id, exp_id);
            end
            ack_pulse();
        end
        checks++;
        if (evt_valid !== 1'b0 || evt_count !== 3'd0) begin
            errors++;
            $display("FAIL full_empty: got v=%b cnt=%0d want 0/0", evt_valid, evt_count);
        end
    endtask

    task automatic test_mid_reset();
        press_btn(0, 1);
        press_btn(1, 1);
        btn_raw[2] = 1'b1;
        sb.push_back(3);
        cyc(9);
        checks++;
        if (evt_count !== 3'd3) begin
            errors++;
            $display("FAIL mreset_pre: got cnt=%0d want 3", evt_count);
        end
        rst = 1'b1;
        cyc(1);
        sb.delete();
        checks++;
        if (evt_valid !== 1'b0 || drop_cnt !== 8'd0 || btn_level !== 3'b000 || evt_count !== 3'd0) begin
            errors++;
            $display("FAIL mreset_clear: got v=%b drop=%0d lvl=%b cnt=%0d want 0/0/000/0",
                     evt_valid, drop_cnt, btn_level, evt_count);
        end
        rst = 1'b0;
        cyc(5);
        checks++;
        if (btn_press !== 3'b000) begin
            errors++;
            $display("FAIL mreset_early: got prs=%b want 000", btn_press);
        end
        cyc(1);
        checks++;
        if (btn_press !== 3'b100) begin
            errors++;
            $display("FAIL mreset_press: got prs=%b want 100", btn_press);
        end
        sb.push_back(3);
        cyc(2);
        exp_id = sb.size() > 0 ? sb.pop_front() : -1;
        checks++;
        if (evt_valid !== 1'b1 || int'(evt_id) !== exp_id || evt_count !== 3'd1) begin
            errors++;
            $display("FAIL mreset_event: got v=%b id=%0d cnt=%0d want 1/%0d/1", evt_valid, evt_id, evt_count, exp_id);
        end
        btn_raw = 3'b000;
        cyc(8);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_ack_empty();
        test_full_drop();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_event_queue.md
# btn_event_queue

Input-conditioning stage between the three raw game buttons and the game logic (zombie hit detection, random-request detector). It synchronizes and debounces each button and emits a clean level and a one-cycle press pulse per button. It also queues press events as button IDs in a 4-entry first-word-fall-through FIFO, so a consumer can take hits one at a time with a valid/ack handshake. No press is lost unless a button is re-pressed while its previous press still waits for queue space.

## Interface

- DEB_CYCLES, 250000: consecutive stable cycles required before a debounced level changes; must be ≥ 2.
- CNT_W, 18: debounce counter width; 2^CNT_W must be > DEB_CYCLES.
- clk  in  1  block clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  3  raw buttons, active-high; bit0 = button 1, bit1 = button 2, bit2 = button 3.
- btn_level  out  3  debounced button levels.
- btn_press  out  3  one-cycle pulse on each debounced rising edge.
- evt_valid  out  1  FIFO non-empty; evt_id is valid.
- evt_id  out  2  head event button ID: 1, 2 or 3. Never 0 while evt_valid = 1.
- evt_ack  in  1  pops the head when evt_valid = 1.
- evt_count  out  3  FIFO occupancy, 0..4.
- drop_cnt  out  8  saturating count of lost presses.

## Operation

- Synchronizer: two flops per bit, reset to 0.
- Debounce, per channel i:
  - If sync[i] == btn_level[i], clear cnt[i].
  - Otherwise, if cnt[i] == DEB_CYCLES-1, then btn_level[i] <= sync[i] and cnt[i] <= 0.
  - Otherwise, cnt[i] increments.
  - Any glitch shorter than DEB_CYCLES cycles at the sync output is ignored.
- btn_press[i] is registered. It is 1 exactly in the first cycle btn_level[i] reads 1. Falling edges produce no pulse.
- Pending flags, pend[2:0]:
  - A btn_press[i] sets pend[i] at the next edge.
  - If pend[i] is already 1 and is not being cleared in that cycle, the press is dropped and drop_cnt increments, saturating at 255.
  - If pend[i] is cleared and set in the same cycle, it stays 1 and nothing is dropped.
- Arbiter:
  - Each cycle, if pend ≠ 0 and the FIFO can accept a write, the lowest-index pending channel is written as ID i+1 and its pend bit is cleared.
  - The FIFO can accept a write when evt_count < 4, or when evt_count == 4 and a pop occurs in the same cycle.
  - At most one write per cycle.
- FIFO:
  - 4 entries of 2 bits, with read pointer, write pointer and a 3-bit count.
  - evt_valid = (evt_count ≠ 0). evt_id is the head entry, combinational from storage.
  - Pop = evt_valid & evt_ack. An ack while empty is ignored.
  - Simultaneous push and pop leaves the count unchanged, including at count 4.
  - Pointers wrap modulo 4.
- Reset clears:
  - sync flops, cnt, btn_level, btn_press, pend;
  - FIFO pointers and count, so evt_valid = 0 and evt_id = 0;
  - drop_cnt.
- Reset mid-operation: FIFO contents are discarded. A button held through reset re-debounces from level 0 and yields a fresh press DEB_CYCLES+2 cycles after rst falls.

## Timing

- Raw rising edge set up before edge E0: btn_level and btn_press go to 1 after edge E0+DEB_CYCLES+1, i.e. DEB_CYCLES+2 cycles of latency.
- Press pulse visible in cycle N: pend visible in N+1, FIFO written at the end of N+1, evt_valid visible in N+2 when the FIFO was empty.
- Pop at edge M: the next head, or evt_valid = 0, is visible after M.
- Two buttons pressed in the same cycle: FIFO writes land on consecutive cycles, lower ID first.
- Release latency equals press latency. There is no release event.

## Test plan

All scenarios use DEB_CYCLES = 4.

- **Clean press:** btn_raw[1] high for 20 cycles, no ack. btn_level[1] rises 6 cycles after raw, with a single btn_press[1] pulse. evt_valid = 1 and evt_id = 2 two cycles after the pulse. evt_count = 1.
- **Bounce:** btn_raw[0] toggles every 2 cycles for 12 cycles, then stays low. btn_level stays 0, no press pulse, evt_valid stays 0.
- **Simultaneous press:** btn_raw[0] and btn_raw[2] rise in the same cycle, no ack. The FIFO receives ID 1 then ID 3 on consecutive cycles. evt_count = 2. Two acks read 1 then 3, after which evt_valid = 0.
- **Full and drop:**
  - Press 1, 2, 3, 1, 2 with no ack: the first four are queued (count 4) and pend[1] is set.
  - Pressing button 2 again: drop_cnt = 1.
  - One ack: pops ID 1; ID 2 is written in the same cycle, count stays 4.
- **Ack edge cases:**
  - evt_ack held high with an empty FIFO: no change, count 0.
  - Ack in the same cycle as a write at count 4: count stays 4 and the order is preserved.
- **Reset:** rst for 1 cycle with 3 events queued and button 3 held. Next cycle: evt_valid = 0, drop_cnt = 0, btn_level = 0. Then btn_press[2] fires 6 cycles after rst falls, and evt_id = 3 appears 2 cycles later.
